multi_counter_display: RTL and testbench

- N-channel push-button counter bank driving one multiplexed 7-segment display.
- Each channel counts up/down in HEX or DEC, has clear and a sticky overflow flag, and optional leading-zero blanking.
- The display shows one channel at a time. Channels are paged manually or by an auto-scroll timer.
- Sits between the per-button debouncers (single-cycle pulses) and the board anode/cathode pins. Generalises the fixed 2-display, 2-counter top.

---
 rtl/seg_disp_pkg.sv | 52 +++++
 rtl/digit_counter.sv | 97 +++++++++
 rtl/multi_counter_display.sv | 120 ++++++++++++
 tb/tb_multi_counter_display.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// Shared types, 7-segment glyph decode and timing helpers for the
// multiplexed counter display.
package seg_disp_pkg;

  typedef enum logic {
    MODE_HEX = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  localparam logic [6:0] BLANK_SEG = 7'h7F;

  // Active-low segments, bit0 = A ... bit6 = G; lowercase glyphs for b and d.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = BLANK_SEG;
    endcase
    return seg;
  endfunction

  function automatic int unsigned refr_cycles(input int unsigned clk_per,
                                              input int unsigned refr_rate,
                                              input int unsigned num_seg);
    logic [63:0] cyc;
    cyc = 64'd1_000_000_000 / (64'(clk_per) * 64'(refr_rate) * 64'(num_seg));
    return (cyc == 64'd0) ? 32'd1 : cyc[31:0];
  endfunction

  function automatic int unsigned scroll_cycles(input int unsigned clk_per,
                                                input int unsigned scroll_ms);
    logic [63:0] cyc;
    cyc = (64'(scroll_ms) * 64'd1_000_000) / 64'(clk_per);
    return (cyc == 64'd0) ? 32'd1 : cyc[31:0];
  endfunction

endpackage

// File: rtl/digit_counter.sv
// One display channel: NUM_SEGMENTS-nibble HEX/BCD up/down counter with
// clear, clear-on-mode-change and a sticky wrap flag.
module digit_counter
  import seg_disp_pkg::*;
#(
  parameter int NUM_SEGMENTS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inc,
  input  logic                      dec,
  input  logic                      clr,
  input  logic                      mode_dec,
  output logic [4*NUM_SEGMENTS-1:0] value,
  output logic                      ovf
);

  localparam int W = 4 * NUM_SEGMENTS;

  logic [W-1:0] value_q, value_d;
  logic         ovf_q, ovf_d;
  mode_e        mode_q, mode_d;
  logic [W-1:0] inc_val_s, dec_val_s;
  logic         inc_wrap_s, dec_wrap_s;
  logic [3:0]   max_nib_s;

  // Ripple carry/borrow per digit; HEX is the same chain with digit limit F.
  always_comb begin
    max_nib_s  = (mode_q == MODE_DEC) ? 4'd9 : 4'hF;
    inc_val_s  = value_q;
    dec_val_s  = value_q;
    inc_wrap_s = 1'b1;
    dec_wrap_s = 1'b1;
    for (int i = 0; i < NUM_SEGMENTS; i++) begin
      if (inc_wrap_s) begin
        if (value_q[4*i +: 4] == max_nib_s) begin
          inc_val_s[4*i +: 4] = 4'd0;
        end else begin
          inc_val_s[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
          inc_wrap_s          = 1'b0;
        end
      end else begin
        inc_val_s[4*i +: 4] = value_q[4*i +: 4];
      end
      if (dec_wrap_s) begin
        if (value_q[4*i +: 4] == 4'd0) begin
          dec_val_s[4*i +: 4] = max_nib_s;
        end else begin
          dec_val_s[4*i +: 4] = value_q[4*i +: 4] - 4'd1;
          dec_wrap_s          = 1'b0;
        end
      end else begin
        dec_val_s[4*i +: 4] = value_q[4*i +: 4];
      end
    end
  end

  // Command priority: mode change, clear, inc+dec cancel, inc, dec.
  always_comb begin
    value_d = value_q;
    ovf_d   = ovf_q;
    mode_d  = mode_e'(mode_dec);
    if (mode_d != mode_q) begin
      value_d = {W{1'b0}};
    end else if (clr) begin
      value_d = {W{1'b0}};
      ovf_d   = 1'b0;
    end else if (inc && dec) begin
      value_d = value_q;
    end else if (inc) begin
      value_d = inc_val_s;
      ovf_d   = ovf_q | inc_wrap_s;
    end else if (dec) begin
      value_d = dec_val_s;
      ovf_d   = ovf_q | dec_wrap_s;
    end else begin
      value_d = value_q;
    end
  end

  // State registers; mode copy loads the live input so reset causes no spurious clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= {W{1'b0}};
      ovf_q   <= 1'b0;
      mode_q  <= mode_e'(mode_dec);
    end else begin
      value_q <= value_d;
      ovf_q   <= ovf_d;
      mode_q  <= mode_d;
    end
  end

  assign value = value_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/multi_counter_display.sv
// N-channel counter bank multiplexed onto one 7-segment display, with manual
// paging and timed auto-scroll between channels.
module multi_counter_display
  import seg_disp_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int NUM_SEGMENTS = 8,
  parameter int CLK_PER      = 10,
  parameter int REFR_RATE    = 1000,
  parameter int SCROLL_MS    = 1000,
  parameter int BLANK_LZ     = 1
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_CH-1:0]                             inc,
  input  logic [NUM_CH-1:0]                             dec,
  input  logic [NUM_CH-1:0]                             clr,
  input  logic [NUM_CH-1:0]                             mode_dec,
  input  logic                                          page_next,
  input  logic                                          auto_scroll,
  output logic [NUM_SEGMENTS-1:0]                       anode,
  output logic [7:0]                                    cathode,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cur_ch,
  output logic [NUM_CH-1:0]                             ovf
);

  localparam int          CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int          IDX_W      = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;
  localparam int unsigned REFR_CYC   = refr_cycles(CLK_PER, REFR_RATE, NUM_SEGMENTS);
  localparam int unsigned SCROLL_CYC = scroll_cycles(CLK_PER, SCROLL_MS);
  localparam int          RT_W       = $clog2(REFR_CYC + 1);
  localparam int          ST_W       = $clog2(SCROLL_CYC + 1);
  localparam int          W          = 4 * NUM_SEGMENTS;

  logic [W-1:0]            values_s [NUM_CH];
  logic [RT_W-1:0]         refr_q, refr_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ST_W-1:0]         scroll_q, scroll_d;
  logic [CH_W-1:0]         cur_ch_q, cur_ch_d;
  logic [NUM_SEGMENTS-1:0] anode_q, anode_d;
  logic [7:0]              cathode_q, cathode_d;
  logic                    scroll_exp_s, advance_s;
  logic [W-1:0]            sel_s, upper_s;
  logic [3:0]              nib_s;
  logic                    lz_blank_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    digit_counter #(.NUM_SEGMENTS(NUM_SEGMENTS)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .inc      (inc[g]),
      .dec      (dec[g]),
      .clr      (clr[g]),
      .mode_dec (mode_dec[g]),
      .value    (values_s[g]),
      .ovf      (ovf[g])
    );
  end

  // Refresh/scroll timers, channel select and next display frame.
  always_comb begin
    refr_d = refr_q;
    idx_d  = idx_q;
    if (refr_q == RT_W'(REFR_CYC - 1)) begin
      refr_d = {RT_W{1'b0}};
      idx_d  = (idx_q == IDX_W'(NUM_SEGMENTS - 1)) ? {IDX_W{1'b0}} : idx_q + IDX_W'(1);
    end else begin
      refr_d = refr_q + RT_W'(1);
    end

    scroll_exp_s = auto_scroll && (scroll_q == ST_W'(SCROLL_CYC - 1));
    advance_s    = page_next || scroll_exp_s;
    if (!auto_scroll || advance_s) begin
      scroll_d = {ST_W{1'b0}};
    end else begin
      scroll_d = scroll_q + ST_W'(1);
    end

    cur_ch_d = cur_ch_q;
    if (advance_s) begin
      cur_ch_d = (cur_ch_q == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}} : cur_ch_q + CH_W'(1);
    end else begin
      cur_ch_d = cur_ch_q;
    end

    // A digit is a leading zero when it and everything above it is zero.
    sel_s      = values_s[cur_ch_q];
    nib_s      = sel_s[4*idx_q +: 4];
    upper_s    = sel_s >> (4 * idx_q);
    lz_blank_s = (BLANK_LZ != 0) && (idx_q != {IDX_W{1'b0}}) && (upper_s == {W{1'b0}});

    anode_d        = ~(NUM_SEGMENTS'(1) << idx_q);
    cathode_d[7]   = (int'(idx_q) == int'(cur_ch_q)) ? 1'b0 : 1'b1;
    cathode_d[6:0] = lz_blank_s ? BLANK_SEG : seg7_decode(nib_s);
  end

  // Timer, channel and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      refr_q    <= {RT_W{1'b0}};
      idx_q     <= {IDX_W{1'b0}};
      scroll_q  <= {ST_W{1'b0}};
      cur_ch_q  <= {CH_W{1'b0}};
      anode_q   <= {NUM_SEGMENTS{1'b1}};
      cathode_q <= 8'hFF;
    end else begin
      refr_q    <= refr_d;
      idx_q     <= idx_d;
      scroll_q  <= scroll_d;
      cur_ch_q  <= cur_ch_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;
  assign cur_ch  = cur_ch_q;

endmodule

// File: tb/tb_multi_counter_display.sv
// Directed bench: an 8-digit/4-channel instance for display, paging and scroll,
// and a 2-digit/2-channel instance for wrap, BCD and priority behaviour.
module tb_multi_counter_display;

  localparam int SC = 10_000;  // scroll dwell in cycles at CLK_PER=100, SCROLL_MS=1

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] inc_a, dec_a, clr_a, mode_dec_a;
  logic       page_a, auto_a;
  logic [7:0] anode_a, cathode_a;
  logic [1:0] cur_ch_a;
  logic [3:0] ovf_a;
  logic [1:0] inc_b, dec_b, clr_b, mode_dec_b;
  logic       page_b, auto_b;
  logic [1:0] anode_b;
  logic [7:0] cathode_b;
  logic [0:0] cur_ch_b;
  logic [1:0] ovf_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #50 clk = ~clk;

  multi_counter_display #(
    .NUM_CH(4), .NUM_SEGMENTS(8), .CLK_PER(100), .REFR_RATE(1_250_000),
    .SCROLL_MS(1), .BLANK_LZ(1)
  ) dut_a (
    .clk(clk), .reset(reset), .inc(inc_a), .dec(dec_a), .clr(clr_a),
    .mode_dec(mode_dec_a), .page_next(page_a), .auto_scroll(auto_a),
    .anode(anode_a), .cathode(cathode_a), .cur_ch(cur_ch_a), .ovf(ovf_a)
  );

  multi_counter_display #(
    .NUM_CH(2), .NUM_SEGMENTS(2), .CLK_PER(100), .REFR_RATE(1_250_000),
    .SCROLL_MS(1), .BLANK_LZ(1)
  ) dut_b (
    .clk(clk), .reset(reset), .inc(inc_b), .dec(dec_b), .clr(clr_b),
    .mode_dec(mode_dec_b), .page_next(page_b), .auto_scroll(auto_b),
    .anode(anode_b), .cathode(cathode_b), .cur_ch(cur_ch_b), .ovf(ovf_b)
  );

  // Active-high gfedcba glyphs.
  function automatic logic [6:0] glyph_hi(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F; 4'h1: g = 7'h06; 4'h2: g = 7'h5B; 4'h3: g = 7'h4F;
      4'h4: g = 7'h66; 4'h5: g = 7'h6D; 4'h6: g = 7'h7D; 4'h7: g = 7'h07;
      4'h8: g = 7'h7F; 4'h9: g = 7'h6F; 4'hA: g = 7'h77; 4'hB: g = 7'h7C;
      4'hC: g = 7'h39; 4'hD: g = 7'h5E; 4'hE: g = 7'h79; 4'hF: g = 7'h71;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  // Expected cathode of a 2-digit value on digit k while channel cur is shown.
  function automatic logic [7:0] exp_cath(input logic [7:0] v, input int k, input int cur);
    logic [7:0] hi;
    logic [6:0] seg;
    hi = v >> (4 * k);
    if (k != 0 && hi == 8'h00) seg = 7'h7F;
    else seg = ~glyph_hi(hi[3:0]);
    return {(k == cur) ? 1'b0 : 1'b1, seg};
  endfunction

  // Capture both digits of dut_b as they are scanned out.
  task automatic read_b(output logic [15:0] pair, output bit ok);
    bit g1, g0;
    g1 = 1'b0;
    g0 = 1'b0;
    pair = 16'hxxxx;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 40 && !(g1 && g0); i++) begin
      @(negedge clk);
      if (anode_b == 2'b10) begin pair[7:0] = cathode_b; g0 = 1'b1; end
      else if (anode_b == 2'b01) begin pair[15:8] = cathode_b; g1 = 1'b1; end
    end
    ok = g1 && g0;
  endtask

  task automatic test_reset();
    n_checks++; if (anode_a !== 8'hFF) begin n_fail++; $display("FAIL reset_anode_a: got %h want ff", anode_a); end
    n_checks++; if (cathode_a !== 8'hFF) begin n_fail++; $display("FAIL reset_cathode_a: got %h want ff", cathode_a); end
    n_checks++; if (cur_ch_a !== 2'd0) begin n_fail++; $display("FAIL reset_cur_ch_a: got %0d want 0", cur_ch_a); end
    n_checks++; if (ovf_a !== 4'h0) begin n_fail++; $display("FAIL reset_ovf_a: got %h want 0", ovf_a); end
    n_checks++; if (anode_b !== 2'b11) begin n_fail++; $display("FAIL reset_anode_b: got %b want 11", anode_b); end
    n_checks++; if (cathode_b !== 8'hFF) begin n_fail++; $display("FAIL reset_cathode_b: got %h want ff", cathode_b); end
  endtask

  task automatic test_wrap();
    logic [15:0] got, want;
    bit ok;
    @(negedge clk); inc_b[0] = 1'b1;
    repeat (255) @(negedge clk);
    inc_b[0] = 1'b0;
    read_b(got, ok);
    want = {exp_cath(8'hFF, 1, 0), exp_cath(8'hFF, 0, 0)};
    n_checks++; if (!ok || got !== want) begin n_fail++; $display("FAIL wrap_ff: got %h want %h", got, want); end
    n_checks++; if (ovf_b[0] !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf_before: got %b want 0", ovf_b[0]); end
    inc_b[0] = 1'b1; @(negedge clk); inc_b[0] = 1'b0;
    read_b(got, ok);
    want = {exp_cath(8'h00, 1, 0), exp_cath(8'h00, 0, 0)};
    n_checks++; if (!ok || got !== want) begin n_fail++; $display("FAIL wrap_00: got %h want %h", got, want); end
    n_checks++; if (ovf_b[0] !== 1'b1) begin n_fail++; $display("FAIL wrap_ovf_set: got %b want 1", ovf_b[0]); end
    clr_b[0] = 1'b1; @(negedge clk); clr_b[0] = 1'b0;
    n_checks++; if (ovf_b[0] !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf_clr: got %b want 0", ovf_b[0]); end
  endtask

  task automatic test_bcd();
    logic [15:0] got, want;
    bit ok;
    page_b = 1'b1; @(negedge clk); page_b = 1'b0;
    n_checks++; if (cur_ch_b !== 1'b1) begin n_fail++; $display("FAIL bcd_page: got %0d want 1", cur_ch_b); end
    dec_b[1] = 1'b1; @(negedge clk); dec_b[1] = 1'b0;
    read_b(got, ok);
    want = {exp_cath(8'h99, 1, 1), exp_cath(8'h99, 0, 1)};
    n_checks++; if (!ok || got !== want) begin n_fail++; $display("FAIL bcd_under: got %h want %h", got, want); end
    n_checks++; if (ovf_b[1] !== 1'b1) begin n_fail++; $display("FAIL bcd_ovf: got %b want 1", ovf_b[1]); end
    inc_b[1] = 1'b1;
    repeat (11) @(negedge clk);
    inc_b[1] = 1'b0;
    read_b(got, ok);
    want = {exp_cath(8'h10, 1, 1), exp_cath(8'h10, 0, 1)};
    n_checks++; if (!ok || got !== want) begin n_fail++; $display("FAIL bcd_10: got %h want %h", got, want); end
  endtask

  task automatic test_priority();
    logic [15:0] got, want;
    bit ok;
    inc_b[1] = 1'b1; dec_b[1] = 1'b1; @(negedge clk); inc_b[1] = 1'b0; dec_b[1] = 1'b0;
    read_b(got, ok);
    want = {exp_cath(8'h10, 1, 1), exp_cath(8'h10, 0, 1)};
    n_checks++; if (!ok || got !== want) begin n_fail++; $display("FAIL prio_incdec: got %h want %h", got, want); end
    clr_b[1] = 1'b1; inc_b[1] = 1'b1; @(negedge clk); clr_b[1] = 1'b0; inc_b[1] = 1'b0;
    read_b(got, ok);
    want = {exp_cath(8'h00, 1, 1), exp_cath(8'h00, 0, 1)};
    n_checks++; if (!ok || got !== want) begin n_fail++; $display("FAIL prio_clrinc: got %h want %h", got, want); end
    n_checks++; if (ovf_b[1] !== 1'b0) begin n_fail++; $display("FAIL prio_clr_ovf: got %b want 0", ovf_b[1]); end
    mode_dec_b[1] = 1'b0; @(negedge clk);
    dec_b[1] = 1'b1; @(negedge clk); dec_b[1] = 1'b0;
    inc_b[1] = 1'b1;
    repeat (59) @(negedge clk);
    inc_b[1] = 1'b0;
    read_b(got, ok);
    want = {exp_cath(8'h3A, 1, 1), exp_cath(8'h3A, 0, 1)};
    n_checks++; if (!ok || got !== want) begin n_fail++; $display("FAIL prio_3a: got %h want %h", got, want); end
    mode_dec_b[1] = 1'b1; @(negedge clk);
    read_b(got, ok);
    want = {exp_cath(8'h00, 1, 1), exp_cath(8'h00, 0, 1)};
    n_checks++; if (!ok || got !== want) begin n_fail++; $display("FAIL prio_mode_clr: got %h want %h", got, want); end
    n_checks++; if (ovf_b[1] !== 1'b1) begin n_fail++; $display("FAIL prio_mode_ovf: got %b want 1", ovf_b[1]); end
  endtask

  task automatic test_display();
    bit found;
    inc_a[0] = 1'b1;
    repeat (5) @(negedge clk);
    inc_a[0] = 1'b0;
    repeat (3) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (anode_a == 8'hFE) found = 1'b1;
    end
    n_checks++; if (!found || cathode_a !== 8'h12) begin n_fail++; $display("FAIL disp_idx0: got %h want 12 (found %0d)", cathode_a, found); end
    @(negedge clk);
    n_checks++; if (anode_a !== 8'hFD) begin n_fail++; $display("FAIL disp_anode1: got %h want fd", anode_a); end
    n_checks++; if (cathode_a !== 8'hFF) begin n_fail++; $display("FAIL disp_idx1: got %h want ff", cathode_a); end
  endtask

  task automatic test_paging();
    for (int k = 1; k <= 4; k++) begin
      page_a = 1'b1; @(negedge clk); page_a = 1'b0;
      n_checks++; if (cur_ch_a !== 2'(k % 4)) begin n_fail++; $display("FAIL page_%0d: got %0d want %0d", k, cur_ch_a, k % 4); end
      @(negedge clk);
    end
  endtask

  task automatic test_scroll();
    @(negedge clk); auto_a = 1'b1;
    repeat (SC - 1) @(negedge clk);
    n_checks++; if (cur_ch_a !== 2'd0) begin n_fail++; $display("FAIL scroll_early: got %0d want 0", cur_ch_a); end
    @(negedge clk);
    n_checks++; if (cur_ch_a !== 2'd1) begin n_fail++; $display("FAIL scroll_tick: got %0d want 1", cur_ch_a); end
    repeat (SC - 1) @(negedge clk);
    page_a = 1'b1; @(negedge clk); page_a = 1'b0;
    n_checks++; if (cur_ch_a !== 2'd2) begin n_fail++; $display("FAIL scroll_coincide: got %0d want 2", cur_ch_a); end
    repeat (SC - 1) @(negedge clk);
    n_checks++; if (cur_ch_a !== 2'd2) begin n_fail++; $display("FAIL scroll_restart_early: got %0d want 2", cur_ch_a); end
    @(negedge clk);
    n_checks++; if (cur_ch_a !== 2'd3) begin n_fail++; $display("FAIL scroll_restart_tick: got %0d want 3", cur_ch_a); end
    auto_a = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    auto_a = 1'b1;
    dec_a[3] = 1'b1; @(negedge clk); dec_a[3] = 1'b0;
    n_checks++; if (ovf_a !== 4'b1000) begin n_fail++; $display("FAIL mid_ovf_pre: got %b want 1000", ovf_a); end
    inc_a = 4'hF;
    repeat (37) @(negedge clk);
    reset = 1'b1; @(negedge clk);
    n_checks++; if (cur_ch_a !== 2'd0) begin n_fail++; $display("FAIL mid_cur_ch: got %0d want 0", cur_ch_a); end
    n_checks++; if (ovf_a !== 4'h0 || ovf_b !== 2'b00) begin n_fail++; $display("FAIL mid_ovf: got %h/%b want 0/00", ovf_a, ovf_b); end
    n_checks++; if (anode_a !== 8'hFF) begin n_fail++; $display("FAIL mid_anode: got %h want ff", anode_a); end
    n_checks++; if (cathode_a !== 8'hFF) begin n_fail++; $display("FAIL mid_cathode: got %h want ff", cathode_a); end
    reset = 1'b0; inc_a = 4'h0; auto_a = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (anode_a == 8'hFE) found = 1'b1;
    end
    n_checks++; if (!found || cathode_a !== 8'h40) begin n_fail++; $display("FAIL mid_counter_zero: got %h want 40 (found %0d)", cathode_a, found); end
  endtask

  initial begin
    reset = 1'b1;
    inc_a = 4'h0; dec_a = 4'h0; clr_a = 4'h0; mode_dec_a = 4'h0; page_a = 1'b0; auto_a = 1'b0;
    inc_b = 2'b00; dec_b = 2'b00; clr_b = 2'b00; mode_dec_b = 2'b10; page_b = 1'b0; auto_b = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_wrap();
    test_bcd();
    test_priority();
    test_display();
    test_paging();
    test_scroll();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
